// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipeline_pkg                                                    |
// | Purpose  : Shared types and constants for the pipeline hazard controller. |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
package pipeline_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
  } inflight_entry_t;

  // Register 0 is hardwired zero, so it can never match a pending write.
  function automatic logic entry_matches(input inflight_entry_t entry,
                                         input logic [ADDR_WIDTH-1:0] reg_addr);
    return entry.valid && (entry.addr == reg_addr) && (reg_addr != ZERO_REG);
  endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/inflight_window.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : inflight_window                                                 |
// | Purpose  : Shift register of destination registers from execute through  |
// |            writeback, with combinational hit lookups and a pending mask.  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module inflight_window
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  inflight_entry_t            entry_in,
  input  logic [ADDR_WIDTH-1:0]      rs,
  input  logic [ADDR_WIDTH-1:0]      rt,
  output logic                       hit_rs,
  output logic                       hit_rt,
  output logic [2**ADDR_WIDTH-1:0]   pending_mask
);

  inflight_entry_t  r_entries [DEPTH];
  logic [DEPTH-1:0] w_match_rs;
  logic [DEPTH-1:0] w_match_rt;

  // The window advances every cycle regardless of stall, so it always drains.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      r_entries[0] <= entry_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_entries[i] <= r_entries[i-1];
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign w_match_rs[i] = entry_matches(r_entries[i], rs);
    assign w_match_rt[i] = entry_matches(r_entries[i], rt);
  end

  assign hit_rs = |w_match_rs;
  assign hit_rt = |w_match_rt;

  for (genvar r = 0; r < 2**ADDR_WIDTH; r++) begin : g_mask
    logic [DEPTH-1:0] w_match;
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign w_match[i] = entry_matches(r_entries[i], ADDR_WIDTH'(r));
    end
    assign pending_mask[r] = |w_match;
  end

endmodule : inflight_window
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_controller                                               |
// | Purpose  : RAW hazard detection, stall/bubble/flush scheduling and a      |
// |            saturating stall-cycle counter for the five-stage pipeline.   |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module hazard_controller #(
  parameter int ADDR_WIDTH  = pipeline_pkg::ADDR_WIDTH,
  parameter int DEPTH       = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      decode_valid,
  input  logic [ADDR_WIDTH-1:0]     decode_rs,
  input  logic [ADDR_WIDTH-1:0]     decode_rt,
  input  logic [ADDR_WIDTH-1:0]     decode_rd,
  input  logic                      decode_uses_rs,
  input  logic                      decode_uses_rt,
  input  logic                      decode_writes,
  input  logic                      flush,
  output logic                      stall,
  output logic                      bubble,
  output logic [2**ADDR_WIDTH-1:0]  pending_mask,
  output logic [COUNT_WIDTH-1:0]    stall_count
);
  import pipeline_pkg::*;

  inflight_entry_t          w_entry_in;
  logic                     w_hit_rs;
  logic                     w_hit_rt;
  logic                     w_hazard;
  logic                     w_issue;
  logic [COUNT_WIDTH-1:0]   r_stall_count;

  // The decode instruction's own write is not in the window yet, so an
  // instruction with rd == rs only sees older producers.
  inflight_window #(
    .DEPTH        (DEPTH)
  ) u_window (
    .clock        (clock),
    .reset        (reset),
    .entry_in     (w_entry_in),
    .rs           (decode_rs),
    .rt           (decode_rt),
    .hit_rs       (w_hit_rs),
    .hit_rt       (w_hit_rt),
    .pending_mask (pending_mask)
  );

  assign w_hazard = (decode_uses_rs & w_hit_rs) | (decode_uses_rt & w_hit_rt);

  // Flush wins over stall: the killed instruction must not hold the front end.
  assign stall   = decode_valid & w_hazard & ~flush;
  assign w_issue = decode_valid & ~stall & ~flush;
  assign bubble  = ~w_issue;

  assign w_entry_in.valid = w_issue & decode_writes & (decode_rd != ZERO_REG);
  assign w_entry_in.addr  = decode_rd;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign stall_count = r_stall_count;

endmodule : hazard_controller
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hazard_controller                                            |
// | Purpose  : Directed self-checking bench for hazard_controller.            |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_hazard_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        decode_valid;
  logic [4:0]  decode_rs;
  logic [4:0]  decode_rt;
  logic [4:0]  decode_rd;
  logic        decode_uses_rs;
  logic        decode_uses_rt;
  logic        decode_writes;
  logic        flush;
  logic        stall;
  logic        bubble;
  logic [31:0] pending_mask;
  logic [15:0] stall_count;
  logic        s_stall;
  logic        s_bubble;
  logic [31:0] s_pending_mask;
  logic [1:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hazard_controller #(.ADDR_WIDTH(5), .DEPTH(3), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .decode_valid(decode_valid),
    .decode_rs(decode_rs), .decode_rt(decode_rt), .decode_rd(decode_rd),
    .decode_uses_rs(decode_uses_rs), .decode_uses_rt(decode_uses_rt),
    .decode_writes(decode_writes), .flush(flush), .stall(stall),
    .bubble(bubble), .pending_mask(pending_mask), .stall_count(stall_count)
  );

  // Same stimulus, narrow counter to exercise saturation.
  hazard_controller #(.ADDR_WIDTH(5), .DEPTH(3), .COUNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .decode_valid(decode_valid),
    .decode_rs(decode_rs), .decode_rt(decode_rt), .decode_rd(decode_rd),
    .decode_uses_rs(decode_uses_rs), .decode_uses_rt(decode_uses_rt),
    .decode_writes(decode_writes), .flush(flush), .stall(s_stall),
    .bubble(s_bubble), .pending_mask(s_pending_mask), .stall_count(s_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic urs, input logic urt,
                       input logic wr, input logic fl);
    decode_valid = v; decode_rs = rs; decode_rt = rt; decode_rd = rd;
    decode_uses_rs = urs; decode_uses_rt = urt; decode_writes = wr; flush = fl;
  endtask

  // Outputs are sampled at the falling edge, inputs change 1 after the rising edge.
  task automatic sample();
    @(negedge clock);
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) advance();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) advance();
    reset = 1'b0;

    // Reset state
    sample();
    chk("reset_stall", stall, 0);
    chk("reset_pending", pending_mask, 0);
    chk("reset_count", stall_count, 0);
    advance();

    // Independent stream
    drive(1, 1, 2, 3, 1, 1, 1, 0); sample();
    chk("indep_a_stall", stall, 0);
    chk("indep_a_bubble", bubble, 0);
    advance();
    drive(1, 4, 5, 6, 1, 1, 1, 0); sample();
    chk("indep_b_stall", stall, 0);
    chk("indep_b_bubble", bubble, 0);
    chk("indep_b_pending", pending_mask, 32'h0000_0008);
    advance();
    idle(3);
    sample();
    chk("indep_count", stall_count, 0);
    chk("indep_drained", pending_mask, 0);
    advance();

    // RAW distance 1: three stall cycles, issue in the fourth
    drive(1, 1, 2, 3, 1, 1, 1, 0); sample();
    chk("raw1_prod_stall", stall, 0);
    advance();
    drive(1, 3, 4, 5, 1, 1, 1, 0);
    for (int c = 0; c < 3; c++) begin
      sample();
      chk($sformatf("raw1_stall_c%0d", c), stall, 1);
      chk($sformatf("raw1_bubble_c%0d", c), bubble, 1);
      chk($sformatf("raw1_pend3_c%0d", c), pending_mask[3], 1);
      advance();
    end
    sample();
    chk("raw1_issue_stall", stall, 0);
    chk("raw1_issue_bubble", bubble, 0);
    chk("raw1_pend3_clear", pending_mask[3], 0);
    chk("raw1_count", stall_count, 3);
    chk("raw1_sat_count", s_stall_count, 3);
    advance();
    idle(3);

    // RAW distance 3: producer already in writeback, one stall cycle
    drive(1, 1, 2, 3, 1, 1, 1, 0); advance();
    drive(1, 1, 2, 8, 1, 1, 1, 0); advance();
    drive(1, 1, 2, 9, 1, 1, 1, 0); advance();
    drive(1, 3, 4, 10, 1, 1, 1, 0); sample();
    chk("raw3_stall", stall, 1);
    chk("raw3_pending", pending_mask, 32'h0000_0308);
    advance();
    sample();
    chk("raw3_issue_stall", stall, 0);
    chk("raw3_issue_bubble", bubble, 0);
    chk("raw3_count", stall_count, 4);
    chk("raw3_sat_count", s_stall_count, 3);
    advance();
    idle(3);

    // Register 0 never pending; unused operand ignored; rd == rs self-read
    drive(1, 1, 2, 0, 1, 1, 1, 0); advance();
    drive(1, 0, 0, 4, 1, 1, 1, 0); sample();
    chk("r0_stall", stall, 0);
    chk("r0_pending", pending_mask, 0);
    advance();
    drive(1, 1, 2, 7, 1, 1, 1, 0); advance();
    drive(1, 1, 7, 11, 1, 0, 1, 0); sample();
    chk("unused_rt_stall", stall, 0);
    chk("unused_rt_pend7", pending_mask[7], 1);
    advance();
    idle(3);
    drive(1, 12, 1, 12, 1, 1, 1, 0); sample();
    chk("self_read_stall", stall, 0);
    advance();
    idle(3);

    // Flush during a stall
    drive(1, 1, 2, 3, 1, 1, 1, 0); advance();
    drive(1, 3, 4, 5, 1, 1, 1, 0); sample();
    chk("flush_pre_stall", stall, 1);
    advance();
    drive(1, 3, 4, 5, 1, 1, 1, 1); sample();
    chk("flush_stall", stall, 0);
    chk("flush_bubble", bubble, 1);
    chk("flush_pend3", pending_mask[3], 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("flush_wb_pend", pending_mask, 32'h0000_0008);
    advance();
    sample();
    chk("flush_drained", pending_mask, 0);
    chk("flush_count", stall_count, 5);
    chk("flush_sat_count", s_stall_count, 3);
    advance();

    // Reset with three valid entries
    drive(1, 1, 2, 10, 1, 1, 1, 0); advance();
    drive(1, 1, 2, 11, 1, 1, 1, 0); advance();
    drive(1, 1, 2, 12, 1, 1, 1, 0); advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0); sample();
    chk("full_window", pending_mask, 32'h0000_1C00);
    reset = 1'b1;
    advance();
    reset = 1'b0;
    drive(1, 12, 11, 13, 1, 1, 1, 0); sample();
    chk("mid_reset_pending", pending_mask, 0);
    chk("mid_reset_stall", stall, 0);
    chk("mid_reset_count", stall_count, 0);
    chk("mid_reset_sat_count", s_stall_count, 0);
    advance();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_hazard_controller
`default_nettype wire
